// File: rtl/wb_dsp_equation_fetch.sv
// Wishbone master that fetches an equation descriptor from system memory
// and hands it to the DSP datapath over a valid/ready handshake.
module wb_dsp_equation_fetch #(
    parameter int dw         = 32,
    parameter int aw         = 32,
    parameter int DESC_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                       wb_clk,
    input  logic                       wb_rst_n,
    input  logic [dw-1:0]              equation_address_reg,
    input  logic [dw-1:0]              control_reg,
    output logic [dw-1:0]              status_reg,
    output logic                       interrupt,
    output logic [aw-1:0]              wb_m_adr_o,
    input  logic [dw-1:0]              wb_m_dat_i,
    output logic [3:0]                 wb_m_sel_o,
    output logic                       wb_m_we_o,
    output logic                       wb_m_cyc_o,
    output logic                       wb_m_stb_o,
    output logic [2:0]                 wb_m_cti_o,
    output logic [1:0]                 wb_m_bte_o,
    input  logic                       wb_m_ack_i,
    input  logic                       wb_m_err_i,
    input  logic                       wb_m_rty_i,
    output logic [DESC_WORDS*dw-1:0]   desc_data,
    output logic                       desc_valid,
    input  logic                       desc_ready
);

    localparam int IW = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [IW-1:0] LAST = IW'(DESC_WORDS - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        HOLD
    } state_t;

    state_t        state;
    logic          start_q;
    logic          irq_en;
    logic [aw-1:0] base;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic [1:0]    rcnt;
    logic [3:0]    count;
    logic          done;
    logic          error;
    logic          tmo;
    logic          aborted;
    logic          cyc;
    logic          valid;
    logic [dw-1:0] words [DESC_WORDS];
    logic          start;
    logic          abort;
    logic          unused_bits;

    assign start = control_reg[0] & ~start_q & (state == IDLE);
    assign abort = control_reg[2];
    assign unused_bits = ^control_reg[dw-1:3];

    assign wb_m_adr_o = base + aw'({idx, 2'b00});
    assign wb_m_cyc_o = cyc;
    assign wb_m_stb_o = cyc;
    assign wb_m_sel_o = 4'hF;
    assign wb_m_we_o  = 1'b0;
    assign wb_m_cti_o = 3'b000;
    assign wb_m_bte_o = 2'b00;
    assign desc_valid = valid;
    assign interrupt  = irq_en & (done | error | aborted);

    for (genvar k = 0; k < DESC_WORDS; k++) begin : g_pack
        assign desc_data[k*dw +: dw] = words[k];
    end

    // Status word assembled from the registered flags and FSM state.
    always_comb begin
        status_reg       = '0;
        status_reg[0]    = (state != IDLE);
        status_reg[1]    = done;
        status_reg[2]    = error;
        status_reg[3]    = tmo;
        status_reg[4]    = aborted;
        status_reg[11:8] = count;
    end

    // Fetch sequencer: start detect, beat issue, retries, timeout, handoff.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            irq_en  <= 1'b0;
            base    <= '0;
            idx     <= '0;
            tcnt    <= '0;
            rcnt    <= '0;
            count   <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
            tmo     <= 1'b0;
            aborted <= 1'b0;
            cyc     <= 1'b0;
            valid   <= 1'b0;
            for (int k = 0; k < DESC_WORDS; k++) begin
                words[k] <= '0;
            end
        end else begin
            start_q <= control_reg[0];
            irq_en  <= control_reg[1];
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base    <= aw'(equation_address_reg);
                        idx     <= '0;
                        tcnt    <= '0;
                        rcnt    <= '0;
                        count   <= '0;
                        done    <= 1'b0;
                        tmo     <= 1'b0;
                        aborted <= 1'b0;
                        if (equation_address_reg[1:0] != 2'b00) begin
                            error <= 1'b1;
                        end else begin
                            error <= 1'b0;
                            cyc   <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        cyc     <= 1'b0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (wb_m_err_i) begin
                        cyc   <= 1'b0;
                        error <= 1'b1;
                        state <= IDLE;
                    end else if (wb_m_ack_i) begin
                        cyc        <= 1'b0;
                        words[idx] <= wb_m_dat_i;
                        count      <= count + 4'd1;
                        rcnt       <= '0;
                        if (idx == LAST) begin
                            valid <= 1'b1;
                            state <= HOLD;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= GAP;
                        end
                    end else if (wb_m_rty_i) begin
                        cyc <= 1'b0;
                        if (rcnt == 2'd3) begin
                            error <= 1'b1;
                            state <= IDLE;
                        end else begin
                            rcnt  <= rcnt + 2'd1;
                            state <= GAP;
                        end
                    end else if (tcnt == TLIM) begin
                        cyc   <= 1'b0;
                        tmo   <= 1'b1;
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                GAP: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt  <= '0;
                        cyc   <= 1'b1;
                        state <= ISSUE;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        valid   <= 1'b0;
                        aborted <= 1'b1;
                        state   <= IDLE;
                    end else if (desc_ready) begin
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dsp_equation_fetch.sv
// Scoreboard bench for wb_dsp_equation_fetch: expected bus addresses,
// descriptors and final status are queued and checked by a monitor.
module tb_wb_dsp_equation_fetch;

    localparam int DW  = 32;
    localparam int NW  = 4;
    localparam int TO  = 255;
    localparam int DDW = NW * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [31:0]    eq_addr = '0;
    logic [31:0]    ctrl = '0;
    logic [31:0]    status;
    logic           interrupt;
    logic [31:0]    adr;
    logic [31:0]    dat = '0;
    logic [3:0]     sel;
    logic           we;
    logic           cyc;
    logic           stb;
    logic [2:0]     cti;
    logic [1:0]     bte;
    logic           ack = 1'b0;
    logic           err = 1'b0;
    logic           rty = 1'b0;
    logic [DDW-1:0] desc_data;
    logic           desc_valid;
    logic           desc_ready = 1'b0;

    always #5 clk = ~clk;

    wb_dsp_equation_fetch #(
        .dw(DW), .aw(32), .DESC_WORDS(NW), .TIMEOUT(TO)
    ) dut (
        .wb_clk(clk),
        .wb_rst_n(rst_n),
        .equation_address_reg(eq_addr),
        .control_reg(ctrl),
        .status_reg(status),
        .interrupt(interrupt),
        .wb_m_adr_o(adr),
        .wb_m_dat_i(dat),
        .wb_m_sel_o(sel),
        .wb_m_we_o(we),
        .wb_m_cyc_o(cyc),
        .wb_m_stb_o(stb),
        .wb_m_cti_o(cti),
        .wb_m_bte_o(bte),
        .wb_m_ack_i(ack),
        .wb_m_err_i(err),
        .wb_m_rty_i(rty),
        .desc_data(desc_data),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [DDW-1:0] act,
                         input logic [DDW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: got no/extra event want matching event", name);
    endtask

    // Scoreboard queues
    logic [31:0]    q_adr[$];
    logic [DDW-1:0] q_desc[$];
    logic [32:0]    q_stat[$];

    // Slave memory and response script
    logic [31:0] mem [logic [31:0]];
    bit          silent = 0;
    bit          lat_rand = 0;
    logic [31:0] err_adr = 32'h1;
    logic [31:0] rty_adr = 32'h1;
    int          rty_n = 0;
    int          epoch = 0;
    int          seen = 0;
    int          given = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5a5a_5a5a;
    endfunction

    // Registered-response slave
    always @(posedge clk) begin
        if (epoch != seen) begin
            seen = epoch;
            given = 0;
        end
        if (!rst_n) begin
            ack <= 0; err <= 0; rty <= 0;
        end else if (cyc && stb && !(ack || err || rty)) begin
            if (silent || (lat_rand && $urandom_range(0, 2) != 0)) begin
                ack <= 0; err <= 0; rty <= 0;
            end else if (adr == err_adr) begin
                err <= 1;
            end else if (adr == rty_adr && given < rty_n) begin
                rty <= 1;
                given++;
            end else begin
                ack <= 1;
                dat <= mem_rd(adr);
            end
        end else begin
            ack <= 0; err <= 0; rty <= 0;
        end
    end

    // Datapath ready driver
    int ready_mode = 0;
    int rw = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: desc_ready = 0;
            1: desc_ready = 1;
            default: begin
                if (desc_valid) begin
                    if (rw == 0) desc_ready = 1;
                    else rw--;
                end else begin
                    desc_ready = 0;
                    rw = $urandom_range(0, 4);
                end
            end
        endcase
    end

    // Monitor: pop and compare on every DUT-visible event
    bit busy_prev = 0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            busy_prev = 0;
        end else begin
            if (cyc && stb && (ack || err || rty) && !ctrl[2]) begin
                if (q_adr.size() == 0) fail("bus_adr_unexpected");
                else check("bus_adr", adr, q_adr.pop_front());
            end
            if (desc_valid && desc_ready && !ctrl[2]) begin
                if (q_desc.size() == 0) fail("desc_unexpected");
                else check("desc_data", desc_data, q_desc.pop_front());
            end
            if (busy_prev && !status[0]) begin
                if (q_stat.size() == 0) begin
                    fail("status_unexpected");
                end else begin
                    e = q_stat.pop_front();
                    check("status", status, e[31:0]);
                    check("interrupt", interrupt, e[32]);
                end
            end
            busy_prev = status[0];
        end
    end

    // Reference model
    logic [31:0] m_words [NW];

    function automatic logic [DDW-1:0] pack();
        logic [DDW-1:0] v;
        for (int k = 0; k < NW; k++) v[k*32 +: 32] = m_words[k];
        return v;
    endfunction

    task automatic expect_fetch(input logic [31:0] base, input bit irq,
                                input bit abort_hold);
        logic [31:0] st;
        logic [31:0] a;
        int          cnt;
        bit          bad;
        st = 0; cnt = 0; bad = 0;
        for (int k = 0; k < NW && !bad; k++) begin
            a = base + 32'(4 * k);
            if (silent) begin
                st = 32'h0C;
                bad = 1;
            end else if (a == err_adr) begin
                q_adr.push_back(a);
                st = 32'h04;
                bad = 1;
            end else begin
                if (a == rty_adr) begin
                    for (int j = 0; j < rty_n && j < 4; j++) q_adr.push_back(a);
                    if (rty_n >= 4) begin
                        st = 32'h04;
                        bad = 1;
                    end
                end
                if (!bad) begin
                    q_adr.push_back(a);
                    m_words[k] = mem_rd(a);
                    cnt++;
                end
            end
        end
        if (!bad) begin
            if (abort_hold) st = 32'h10;
            else begin
                st = 32'h02;
                q_desc.push_back(pack());
            end
        end
        st[11:8] = 4'(cnt);
        q_stat.push_back({irq & (st[1] | st[2] | st[4]), st});
    endtask

    task automatic cfg(input bit s, input logic [31:0] ea,
                       input logic [31:0] ra, input int rn);
        silent = s; err_adr = ea; rty_adr = ra; rty_n = rn;
        epoch++;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < NW; k++) mem[base + 32'(4 * k)] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [31:0] base, input bit irq, input bit hold);
        eq_addr = base;
        ctrl = {29'b0, 1'b0, irq, 1'b1};
        @(posedge clk);
        #2;
        if (!hold) ctrl[0] = 0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!status[0]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail(name);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int c;
        int stable;
        bit ok;
        logic [DDW-1:0] snap;
        logic [31:0] base;
        int sc;
        int b;
        bit irq;

        for (int k = 0; k < NW; k++) m_words[k] = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("rst_status", status, 0);
        check("rst_irq", interrupt, 0);
        check("rst_ctl", {cyc, stb, we, desc_valid}, 0);
        check("rst_desc", desc_data, 0);
        check("rst_adr", adr, 0);
        check("rst_const", {sel, cti, bte}, {4'hF, 3'b000, 2'b00});
        step();

        // Normal fetch with latency check
        mem[32'h100] = 32'h11111111;
        mem[32'h104] = 32'h22222222;
        mem[32'h108] = 32'h33333333;
        mem[32'h10C] = 32'h44444444;
        cfg(0, 32'h1, 32'h1, 0);
        ready_mode = 1;
        expect_fetch(32'h100, 1, 0);
        start(32'h100, 1, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("valid_early", desc_valid, 0);
        @(negedge clk);
        check("valid_at_11", desc_valid, 1);
        wait_idle("normal_idle");
        check("normal_irq", interrupt, 1);

        // Misaligned base
        start(32'h102, 1, 0);
        @(negedge clk);
        check("misal_status", status, 32'h4);
        check("misal_irq_on", interrupt, 1);
        c = 0;
        repeat (3) begin
            if (cyc) c++;
            @(negedge clk);
        end
        check("misal_nocyc", c, 0);
        step();
        start(32'h102, 0, 0);
        @(negedge clk);
        check("misal_status2", status, 32'h4);
        check("misal_irq_off", interrupt, 0);
        step();

        // Bus error on beat 2
        fill(32'h200);
        cfg(0, 32'h208, 32'h1, 0);
        expect_fetch(32'h200, 1, 0);
        start(32'h200, 1, 0);
        wait_idle("err_idle");
        check("err_words", desc_data, pack());

        // Two retries on beat 0
        fill(32'h240);
        cfg(0, 32'h1, 32'h240, 2);
        expect_fetch(32'h240, 1, 0);
        start(32'h240, 1, 0);
        wait_idle("rty_idle");
        check("rty_words", desc_data, pack());

        // Address wrap
        fill(32'hFFFF_FFF8);
        cfg(0, 32'h1, 32'h1, 0);
        expect_fetch(32'hFFFF_FFF8, 0, 0);
        start(32'hFFFF_FFF8, 0, 0);
        wait_idle("wrap_idle");

        // Randomized fetches
        lat_rand = 1;
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            base = 32'h1000 + 32'($urandom_range(0, 255)) * 16;
            fill(base);
            sc = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            irq = 1'($urandom_range(0, 1));
            case (sc)
                1: cfg(0, base + 32'(4 * b), 32'h1, 0);
                2: cfg(0, 32'h1, base + 32'(4 * b), $urandom_range(0, 5));
                default: cfg(0, 32'h1, 32'h1, 0);
            endcase
            expect_fetch(base, irq, 0);
            start(base, irq, 0);
            wait_idle("rand_idle");
            check("rand_words", desc_data, pack());
        end
        lat_rand = 0;
        ready_mode = 1;

        // Silent slave timeout
        cfg(1, 32'h1, 32'h1, 0);
        expect_fetch(32'h300, 1, 0);
        start(32'h300, 1, 0);
        repeat (TO) @(posedge clk);
        @(negedge clk);
        check("tmo_early", status[3], 0);
        @(negedge clk);
        check("tmo_flags", status[3:2], 2'b11);
        step();

        // Stall then abort in HOLD with ready on the same cycle
        cfg(0, 32'h1, 32'h1, 0);
        ready_mode = 0;
        fill(32'h400);
        expect_fetch(32'h400, 1, 1);
        start(32'h400, 1, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (desc_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("stall_valid");
        snap = desc_data;
        stable = 0;
        repeat (20) begin
            @(negedge clk);
            if (desc_valid && desc_data === snap) stable++;
        end
        check("stall_stable", stable, 20);
        check("stall_data", snap, pack());
        step();
        ready_mode = 1;
        step();
        ctrl[2] = 1;
        @(negedge clk);
        @(negedge clk);
        check("abort_valid", desc_valid, 0);
        check("abort_done", status[1], 0);
        step();
        ctrl[2] = 0;
        step();

        // START held high after completion
        fill(32'h440);
        expect_fetch(32'h440, 1, 0);
        start(32'h440, 1, 1);
        wait_idle("held_idle");
        c = 0;
        repeat (10) begin
            @(negedge clk);
            if (status[0] || cyc) c++;
        end
        check("held_norestart", c, 0);
        step();
        ctrl[0] = 0;
        step();

        // START toggled while busy
        fill(32'h480);
        expect_fetch(32'h480, 0, 0);
        start(32'h480, 0, 0);
        step();
        ctrl[0] = 1;
        step();
        ctrl[0] = 0;
        step();
        ctrl[0] = 1;
        step();
        ctrl[0] = 0;
        wait_idle("toggle_idle");
        c = 0;
        repeat (6) begin
            @(negedge clk);
            if (status[0] || cyc) c++;
        end
        check("toggle_norestart", c, 0);
        step();

        // Reset during ISSUE
        start(32'h500, 1, 0);
        check("pre_rst_cyc", cyc, 1);
        rst_n = 0;
        #1;
        check("midrst_cyc", {cyc, stb}, 0);
        check("midrst_status", status, 0);
        check("midrst_irq", interrupt, 0);
        @(negedge clk);
        step();
        rst_n = 1;
        q_adr.delete();
        q_desc.delete();
        q_stat.delete();
        for (int k = 0; k < NW; k++) m_words[k] = '0;
        check("midrst_desc", desc_data, pack());
        step();

        // Recovery fetch
        expect_fetch(32'h100, 1, 0);
        start(32'h100, 1, 0);
        wait_idle("recover_idle");
        check("recover_words", desc_data, pack());

        repeat (3) @(negedge clk);
        check("q_adr_left", q_adr.size(), 0);
        check("q_desc_left", q_desc.size(), 0);
        check("q_stat_left", q_stat.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
